// File: rtl/alu_bist_driver.sv
// Self-test host for the 8-bit ALU: drives LFSR operands and every opcode, one vector
// at a time, and compacts the results and flags into a 16-bit MISR signature.
module alu_bist_driver #(
  parameter int          OPW     = 3,
  parameter int          NUM_VEC = 256,
  parameter int          ALU_LAT = 1,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter logic [15:0] GOLDEN  = 16'h0000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  output logic [7:0]     alu_a,
  output logic [7:0]     alu_b,
  output logic [OPW-1:0] alu_op,
  output logic           alu_valid,
  input  logic [7:0]     alu_y,
  input  logic [3:0]     alu_flags,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [15:0]    signature
);

  localparam int WCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state, state_nx;
  logic [15:0]    lfsr, sig, vec_cnt;
  logic [WCW-1:0] wait_cnt;

  logic        start_run, capture, last;
  logic [15:0] lfsr_nx, sig_nx, vec_cnt_inc;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [3:0] f,
                                            input logic [7:0] y);
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {4'h0, f, y};
  endfunction

  assign lfsr_nx     = lfsr_step(lfsr);
  assign sig_nx      = misr_step(sig, alu_flags, alu_y);
  assign vec_cnt_inc = vec_cnt + 16'd1;
  assign last        = (vec_cnt == 16'(NUM_VEC - 1));
  assign start_run   = ((state == IDLE) || (state == DONE)) && start;
  // abort beats the capture scheduled for the same edge
  assign capture     = !abort && (((state == ISSUE) && (ALU_LAT == 0)) ||
                                  ((state == WAIT) && (wait_cnt == '0)));
  assign signature   = sig;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = ISSUE;
      ISSUE: begin
        if (abort)              state_nx = IDLE;
        else if (ALU_LAT != 0)  state_nx = WAIT;
        else if (last)          state_nx = DONE;
      end
      WAIT: begin
        if (abort)                  state_nx = IDLE;
        else if (wait_cnt == '0)    state_nx = last ? DONE : ISSUE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= SEED;
      sig       <= 16'hFFFF;
      vec_cnt   <= '0;
      wait_cnt  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      alu_valid <= (state_nx == ISSUE);
      if (start_run) begin
        lfsr    <= SEED;
        sig     <= 16'hFFFF;
        vec_cnt <= '0;
        alu_a   <= SEED[7:0];
        alu_b   <= SEED[15:8];
        alu_op  <= '0;
        busy    <= 1'b1;
        done    <= 1'b0;
        pass    <= 1'b0;
      end else if (busy && abort) begin
        busy <= 1'b0;
      end else begin
        if ((state == ISSUE) && (ALU_LAT != 0)) wait_cnt <= WCW'(ALU_LAT - 1);
        else if (state == WAIT)                 wait_cnt <= wait_cnt - 1'b1;
        if (capture) begin
          sig     <= sig_nx;
          lfsr    <= lfsr_nx;
          vec_cnt <= vec_cnt_inc;
          alu_a   <= lfsr_nx[7:0];
          alu_b   <= lfsr_nx[15:8];
          alu_op  <= vec_cnt_inc[OPW-1:0];
          if (last) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (sig_nx == GOLDEN);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_bist_driver.sv
// Directed bench for alu_bist_driver: stub-ALU runs at two latencies, abort, reset and
// busy-start corners, and a full run against a behavioural ALU with a fault hook.
module tb_alu_bist_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    logic [8:0] t;
    logic [7:0] y;
    logic c, v;
    c = 1'b0; v = 1'b0; t = '0;
    case (op)
      3'd0: begin t = {1'b0, a} + {1'b0, b}; y = t[7:0]; c = t[8];
                  v = (a[7] == b[7]) && (y[7] != a[7]); end
      3'd1: begin t = {1'b0, a} - {1'b0, b}; y = t[7:0]; c = t[8];
                  v = (a[7] != b[7]) && (y[7] != a[7]); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: begin y = {a[6:0], 1'b0}; c = a[7]; end
      3'd6: begin y = {1'b0, a[7:1]}; c = a[0]; end
      default: y = a;
    endcase
    return {c, (y == 8'h00), y[7], v, y};
  endfunction

  function automatic logic [15:0] calc_sig(input int n, input int fidx, input logic [11:0] fmask);
    logic [15:0] l, s;
    logic [11:0] r;
    l = 16'hACE1; s = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      r = alu_f(l[7:0], l[15:8], 3'(i));
      if (i == fidx) r = r ^ fmask;
      s = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {4'h0, r};
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    return s;
  endfunction

  localparam logic [15:0] GOLD = calc_sig(16, -1, 12'h000);
  localparam int          FIDX = 5;

  // stub-ALU instances (y=0, flags=0): d1 has ALU_LAT=1, d0 is combinational
  logic st1 = 0, ab1 = 0, st0 = 0, ab0 = 0, st2 = 0, ab2 = 0;
  logic [7:0] a1, b1, a0, b0, a2, b2;
  logic [2:0] op1, op0, op2;
  logic v1, v0, v2, busy1, busy0, busy2, done1, done0, done2, pass1, pass0, pass2;
  logic [15:0] sig1, sig0, sig2;
  logic [7:0] y2 = 8'h00;
  logic [3:0] f2 = 4'h0;
  logic fault_en = 1'b0;
  int   vidx = 0;

  alu_bist_driver #(.OPW(3), .NUM_VEC(4), .ALU_LAT(1), .SEED(16'hACE1), .GOLDEN(16'hFFF0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .abort(ab1), .alu_a(a1), .alu_b(b1), .alu_op(op1),
    .alu_valid(v1), .alu_y(8'h00), .alu_flags(4'h0), .busy(busy1), .done(done1), .pass(pass1),
    .signature(sig1));

  alu_bist_driver #(.OPW(3), .NUM_VEC(4), .ALU_LAT(0), .SEED(16'hACE1), .GOLDEN(16'h0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .abort(ab0), .alu_a(a0), .alu_b(b0), .alu_op(op0),
    .alu_valid(v0), .alu_y(8'h00), .alu_flags(4'h0), .busy(busy0), .done(done0), .pass(pass0),
    .signature(sig0));

  alu_bist_driver #(.OPW(3), .NUM_VEC(16), .ALU_LAT(1), .SEED(16'hACE1), .GOLDEN(GOLD)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .abort(ab2), .alu_a(a2), .alu_b(b2), .alu_op(op2),
    .alu_valid(v2), .alu_y(y2), .alu_flags(f2), .busy(busy2), .done(done2), .pass(pass2),
    .signature(sig2));

  // behavioural one-cycle ALU with a single-bit fault hook on vector FIDX
  always @(posedge clk) begin
    if (st2) vidx <= 0;
    else if (v2) begin
      vidx <= vidx + 1;
      {f2, y2} <= alu_f(a2, b2, op2) ^ ((fault_en && vidx == FIDX) ? 12'h001 : 12'h000);
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [15:0] sig;
  } vec_t;
  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fire_start(input int which);
    @(negedge clk);
    if (which == 0) st0 = 1'b1; else if (which == 1) st1 = 1'b1; else st2 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
  endtask

  // start one stub instance and check every issued vector and the done edge
  task automatic run_stub(input bit sel0, input int stride, input int exp_done, input bit exp_pass);
    int nv, done_k;
    logic v, d;
    nv = 0; done_k = -1;
    fire_start(sel0 ? 0 : 1);
    for (int k = 0; k <= 30 && done_k < 0; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      v = sel0 ? v0 : v1;
      d = sel0 ? done0 : done1;
      if (v) begin
        check("vld_edge", k, nv * stride);
        if (nv < 4) begin
          check("op_a",  sel0 ? a0 : a1,     tbl[nv].a);
          check("op_b",  sel0 ? b0 : b1,     tbl[nv].b);
          check("op_op", sel0 ? op0 : op1,   tbl[nv].op);
          check("sig_at_issue", sel0 ? sig0 : sig1, tbl[nv].sig);
        end
        nv++;
      end
      if (d) done_k = k;
    end
    check("vld_count", nv, 4);
    check("done_edge", done_k, exp_done);
    check("final_sig", sel0 ? sig0 : sig1, 16'hFFF0);
    check("pass",      sel0 ? pass0 : pass1, exp_pass);
    check("busy_done", sel0 ? busy0 : busy1, 0);
  endtask

  task automatic wait_done1(input int lim, output int k_out);
    k_out = -1;
    for (int k = 1; k <= lim && k_out < 0; k++) begin
      @(posedge clk); #1;
      if (done1) k_out = k;
    end
  endtask

  initial begin
    int dk;
    tbl[0] = '{8'hE1, 8'hAC, 3'd0, 16'hFFFF};
    tbl[1] = '{8'hC3, 8'h59, 3'd1, 16'hFFFE};
    tbl[2] = '{8'h87, 8'hB3, 3'd2, 16'hFFFC};
    tbl[3] = '{8'h0F, 8'h67, 3'd3, 16'hFFF8};

    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_pass", pass1, 0);
    check("rst_vld",  v1, 0);
    check("rst_sig",  sig1, 16'hFFFF);
    check("rst_a",    a1, 0);
    check("rst_b",    b1, 0);
    check("rst_sig0", sig0, 16'hFFFF);

    run_stub(1'b0, 2, 8, 1'b1);
    run_stub(1'b1, 1, 4, 1'b0);

    // abort in the WAIT of vector 2 (after edge 5), frozen state, then restart with abort high
    fire_start(1);
    repeat (5) @(posedge clk);
    #1;
    check("pre_abort_busy", busy1, 1);
    ab1 = 1'b1;
    @(posedge clk); #1;
    ab1 = 1'b0;
    check("abort_busy", busy1, 0);
    check("abort_done", done1, 0);
    check("abort_vld",  v1, 0);
    check("abort_sig",  sig1, 16'hFFFC);
    check("abort_cnt",  dut1.vec_cnt, 2);
    repeat (2) @(posedge clk);
    #1;
    check("frozen_sig", sig1, 16'hFFFC);
    check("frozen_busy", busy1, 0);
    @(negedge clk); st1 = 1'b1; ab1 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0; ab1 = 1'b0;
    check("restart_busy", busy1, 1);
    check("restart_a",    a1, 8'hE1);
    check("restart_b",    b1, 8'hAC);
    check("restart_sig",  sig1, 16'hFFFF);
    wait_done1(20, dk);
    check("restart_done_edge", dk, 8);
    @(negedge clk); ab1 = 1'b1;
    @(posedge clk); #1;
    ab1 = 1'b0;
    check("abort_in_done", done1, 1);
    check("abort_in_done_pass", pass1, 1);

    // asynchronous reset in the middle of a run
    fire_start(1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy1, 0);
    check("mid_rst_vld",  v1, 0);
    check("mid_rst_a",    a1, 0);
    check("mid_rst_sig",  sig1, 16'hFFFF);
    check("mid_rst_done", done1, 0);
    @(negedge clk); rst_n = 1'b1;

    // start pulsed while busy must not restart the run
    fire_start(1);
    repeat (3) @(posedge clk);
    @(negedge clk); st1 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0;
    check("busy_start_vld", v1, 1);
    check("busy_start_a",   a1, 8'h87);
    check("busy_start_op",  op1, 3'd2);
    check("busy_start_cnt", dut1.vec_cnt, 2);
    wait_done1(20, dk);
    check("busy_start_done_edge", dk + 4, 8);

    // full run against the behavioural ALU, then the same run with one flipped result bit
    for (int pass_i = 0; pass_i < 2; pass_i++) begin
      fault_en = (pass_i == 1);
      fire_start(2);
      dk = -1;
      for (int k = 1; k <= 100 && dk < 0; k++) begin
        @(posedge clk); #1;
        if (done2) dk = k;
      end
      check("full_done_edge", dk, 32);
      if (pass_i == 0) begin
        check("full_sig",  sig2, GOLD);
        check("full_pass", pass2, 1);
      end else begin
        check("fault_sig",  sig2, calc_sig(16, FIDX, 12'h001));
        check("fault_pass", pass2, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
